// File: rtl/arb_pkg.sv
// Shared types, sizes and the rotating first-one search for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Returns the first set bit of req when searching ptr, ptr+1, ..., ptr+N-1 (mod N).
    // Falls back to ptr when req is all zero; callers gate on |req.
    function automatic logic [IDX_W-1:0] rr_first(input logic [N-1:0] req,
                                                  input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] cand;
        rr_first = ptr;
        // Walk from the farthest offset down so the nearest set bit wins last.
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                rr_first = cand;
            end
        end
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating first-one finder: picks the requester nearest to ptr.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    assign idx   = rr_first(req, ptr);
    assign found = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, ack/abandon/timeout release.
// Optional build macro ARB_IDX_OUT_EN adds a registered binary grant index port idx.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             ack,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic             timeout
`ifdef ARB_IDX_OUT_EN
    ,
    output logic [IDX_W-1:0] idx
`endif
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state, state_nx;
    logic [N-1:0]     gnt_nx;
    logic [IDX_W-1:0] ptr, ptr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             timeout_nx;

    logic [IDX_W-1:0] pick_idx;
    logic             found;
    logic [IDX_W-1:0] grantee;
    logic             held, tmo_hit, release_now, tmo_only;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (found)
    );

    // gnt is one-hot while granted, so a search from 0 recovers its index.
    assign grantee     = rr_first(gnt, '0);
    assign held        = |(req & gnt);
    assign tmo_hit     = (TIMEOUT != 0) && (cnt == CNT_MAX);
    assign release_now = ack || !held || tmo_hit;
    assign tmo_only    = !ack && held && tmo_hit;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx   = state;
        gnt_nx     = gnt;
        ptr_nx     = ptr;
        cnt_nx     = cnt;
        timeout_nx = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx         = GRANT;
                    gnt_nx           = '0;
                    gnt_nx[pick_idx] = 1'b1;
                    cnt_nx           = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nx   = IDLE;
                    gnt_nx     = '0;
                    ptr_nx     = grantee + IDX_W'(1);
                    timeout_nx = tmo_only;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            gnt_valid <= (state_nx == GRANT);
            timeout   <= timeout_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
        end
    end

`ifdef ARB_IDX_OUT_EN
    // Index tracks each new grant and holds through the idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (state == IDLE && found) begin
            idx <= pick_idx;
        end
    end
`endif

endmodule
